mem_port_ctrl: RTL

Two-requester controller for the single-port 16-bit word memory, shared by instruction fetch (I-port, read-only) and data access (D-port, read/write).
- Each request moves one 32-bit word as two sequential memory cycles: low half at addr, high half at addr+1.
- Drives the memory's active-low write and output-enable strobes, and returns read data with a one-cycle done pulse.
- Sits between the pipeline's IF/MEM stages and the memory.

---
 rtl/mem_port_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl
//   Arbitrates between an instruction-fetch port and a data port for one
//   single-port, DATAWIDTH-wide memory. Each request moves a 2*DATAWIDTH word
//   in two memory cycles: the low half at addr, then the high half at addr+1.
//   The address wraps modulo 2**ADDRWIDTH.
//
//   Build option MEMCTRL_RR_EN:
//     defined   -> round-robin arbitration between the two ports
//     undefined -> fixed priority, D-port over I-port
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   i_req/i_addr           instruction read request, held until i_done
//   i_rdata/i_done         fetched word and its one-cycle completion pulse
//   d_req/d_we/d_addr      data request (1=write), held until d_done
//   d_wdata                write data
//   d_rdata/d_done         read data and its one-cycle completion pulse
//   mem_addr/mem_din       memory address and write data
//   mem_write_n            memory write strobe, active-low
//   mem_enable_n           memory output enable, active-low
//   mem_dout               memory read data
//   busy                   high whenever a transaction is in flight
//
// All outputs are registered; no input reaches an output combinationally.

module mem_port_ctrl #(
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_req,
  input  logic [ADDRWIDTH-1:0]   i_addr,
  output logic [2*DATAWIDTH-1:0] i_rdata,
  output logic                   i_done,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [ADDRWIDTH-1:0]   d_addr,
  input  logic [2*DATAWIDTH-1:0] d_wdata,
  output logic [2*DATAWIDTH-1:0] d_rdata,
  output logic                   d_done,
  output logic [ADDRWIDTH-1:0]   mem_addr,
  output logic                   mem_write_n,
  output logic                   mem_enable_n,
  output logic [DATAWIDTH-1:0]   mem_din,
  input  logic [DATAWIDTH-1:0]   mem_dout,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t                 state_reg, state_next;
  logic                   owner_d_reg, owner_d_next;   // 1 = D-port owns the transaction
  logic                   we_reg, we_next;
  logic [ADDRWIDTH-1:0]   addr_reg, addr_next;
  logic [DATAWIDTH-1:0]   wdata_hi_reg, wdata_hi_next; // low half goes out straight from IDLE
  logic [ADDRWIDTH-1:0]   mem_addr_reg, mem_addr_next;
  logic                   mem_write_n_reg, mem_write_n_next;
  logic                   mem_enable_n_reg, mem_enable_n_next;
  logic [DATAWIDTH-1:0]   mem_din_reg, mem_din_next;
  logic [2*DATAWIDTH-1:0] i_rdata_reg, i_rdata_next;
  logic [2*DATAWIDTH-1:0] d_rdata_reg, d_rdata_next;
  logic                   i_done_reg, i_done_next;
  logic                   d_done_reg, d_done_next;
  logic                   grant_d;

`ifdef MEMCTRL_RR_EN
  logic last_d_reg, last_d_next;                       // 1 = D was granted last

  // On contention, the port that did not win last time gets the grant.
  always_comb begin
    grant_d = d_req && (!i_req || !last_d_reg);
  end
`else
  always_comb begin
    grant_d = d_req;
  end
`endif

  assign i_rdata      = i_rdata_reg;
  assign i_done       = i_done_reg;
  assign d_rdata      = d_rdata_reg;
  assign d_done       = d_done_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_write_n  = mem_write_n_reg;
  assign mem_enable_n = mem_enable_n_reg;
  assign mem_din      = mem_din_reg;
  assign busy         = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      owner_d_reg      <= 1'b0;
      we_reg           <= 1'b0;
      addr_reg         <= '0;
      wdata_hi_reg     <= '0;
      mem_addr_reg     <= '0;
      mem_write_n_reg  <= 1'b1;
      mem_enable_n_reg <= 1'b1;
      mem_din_reg      <= '0;
      i_rdata_reg      <= '0;
      d_rdata_reg      <= '0;
      i_done_reg       <= 1'b0;
      d_done_reg       <= 1'b0;
`ifdef MEMCTRL_RR_EN
      last_d_reg       <= 1'b0;
`endif
    end else begin
      state_reg        <= state_next;
      owner_d_reg      <= owner_d_next;
      we_reg           <= we_next;
      addr_reg         <= addr_next;
      wdata_hi_reg     <= wdata_hi_next;
      mem_addr_reg     <= mem_addr_next;
      mem_write_n_reg  <= mem_write_n_next;
      mem_enable_n_reg <= mem_enable_n_next;
      mem_din_reg      <= mem_din_next;
      i_rdata_reg      <= i_rdata_next;
      d_rdata_reg      <= d_rdata_next;
      i_done_reg       <= i_done_next;
      d_done_reg       <= d_done_next;
`ifdef MEMCTRL_RR_EN
      last_d_reg       <= last_d_next;
`endif
    end
  end

  always_comb begin
    state_next        = state_reg;
    owner_d_next      = owner_d_reg;
    we_next           = we_reg;
    addr_next         = addr_reg;
    wdata_hi_next     = wdata_hi_reg;
    mem_addr_next     = mem_addr_reg;
    mem_write_n_next  = mem_write_n_reg;
    mem_enable_n_next = mem_enable_n_reg;
    mem_din_next      = mem_din_reg;
    i_rdata_next      = i_rdata_reg;
    d_rdata_next      = d_rdata_reg;
    i_done_next       = 1'b0;
    d_done_next       = 1'b0;
`ifdef MEMCTRL_RR_EN
    last_d_next       = last_d_reg;
`endif

    case (state_reg)
      IDLE: begin
        mem_write_n_next  = 1'b1;
        mem_enable_n_next = 1'b1;
        if (i_req || d_req) begin
          owner_d_next  = grant_d;
          we_next       = grant_d && d_we;
          addr_next     = grant_d ? d_addr : i_addr;
          wdata_hi_next = d_wdata[2*DATAWIDTH-1:DATAWIDTH];
          mem_addr_next = grant_d ? d_addr : i_addr;
          if (grant_d && d_we) begin
            mem_write_n_next = 1'b0;
            mem_din_next     = d_wdata[DATAWIDTH-1:0];
          end else begin
            mem_enable_n_next = 1'b0;
          end
`ifdef MEMCTRL_RR_EN
          last_d_next = grant_d;
`endif
          state_next = LO;
        end
      end

      LO: begin
        if (!we_reg) begin
          if (owner_d_reg) d_rdata_next[DATAWIDTH-1:0] = mem_dout;
          else             i_rdata_next[DATAWIDTH-1:0] = mem_dout;
        end
        // Strobes stay as they are; the address steps to the high half and
        // wraps naturally at the top of the address space.
        mem_addr_next = addr_reg + ADDRWIDTH'(1);
        if (we_reg) mem_din_next = wdata_hi_reg;
        state_next = HI;
      end

      HI: begin
        if (!we_reg) begin
          if (owner_d_reg) d_rdata_next[2*DATAWIDTH-1:DATAWIDTH] = mem_dout;
          else             i_rdata_next[2*DATAWIDTH-1:DATAWIDTH] = mem_dout;
        end
        mem_write_n_next  = 1'b1;
        mem_enable_n_next = 1'b1;
        i_done_next       = !owner_d_reg;
        d_done_next       = owner_d_reg;
        state_next        = DONE;
      end

      DONE: begin
        // No grant here: the requester uses this cycle to drop or replace
        // its request before arbitration happens again.
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
